// File: rtl/keyenc_scan_pkg.sv
// Shared definitions for the key scanner: debounce FSM state encodings and counter width.
package keyenc_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } kstate_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/keyenc_scan_evfifo.sv
// Small synchronous event FIFO with flush and sticky drop-on-full flag.
// Read data is registered storage only (no fall-through); dout reads 0 when empty.
module key_evfifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (occ == '0);
    assign full    = (occ == FULL_OCC);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                occ <= occ + (AW+1)'(1);
            else if (!do_push && do_pop)
                occ <= occ - (AW+1)'(1);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/keyenc_scan.sv
// Key scanner: synchronise raw key lines, lowest-index priority encode, debounce,
// and queue press (and optionally release) events for a valid/ready consumer.
module keyenc_scan
    import keyenc_scan_pkg::*;
#(
    parameter int NKEYS     = 16,
    parameter int VAL_W     = 4,
    parameter int DB_CYCLES = 4,
    parameter int DEPTH     = 4,
    parameter int REL_EV    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NKEYS-1:0] keys,
    input  logic             clear,
    output logic             key_in,
    output logic [VAL_W-1:0] key_val,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [VAL_W-1:0] ev_val,
    output logic             ev_rel,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] DB_CNT = CNT_W'(DB_CYCLES);

    function automatic logic [VAL_W-1:0] prio_enc(input logic [NKEYS-1:0] v);
        prio_enc = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (v[i]) prio_enc = i[VAL_W-1:0];
        end
    endfunction

    logic [NKEYS-1:0] sync_p0;
    logic [NKEYS-1:0] sync_p1;
    logic [VAL_W-1:0] cand;
    logic             key_any;

    kstate_t          state;
    kstate_t          state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [VAL_W-1:0] hv;
    logic [VAL_W-1:0] hv_nx;
    logic             push;
    logic             push_rel;
    logic             empty;
    logic [VAL_W:0]   head;

    // Stage p0/p1: two-flop synchroniser for the asynchronous key lines
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= keys;
            sync_p1 <= sync_p0;
        end
    end

    assign cand    = prio_enc(sync_p1);
    assign key_any = |sync_p1;

    // Debounce FSM operating on the synchronised sample
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hv    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hv    <= hv_nx;
        end
    end

    // cnt counts stable samples seen so far; acceptance once it has reached DB_CYCLES.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hv_nx    = hv;
        push     = 1'b0;
        push_rel = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_any) begin
                    state_nx = ST_PRESS;
                    cnt_nx   = CNT_W'(1);
                    hv_nx    = cand;
                end
            end
            ST_PRESS: begin
                if (!key_any) begin
                    state_nx = ST_IDLE;
                end else if (cand != hv) begin
                    hv_nx  = cand;
                    cnt_nx = CNT_W'(1);
                end else if (cnt >= DB_CNT) begin
                    state_nx = ST_HELD;
                    push     = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!key_any) begin
                    state_nx = ST_RELEASE;
                    cnt_nx   = CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (key_any) begin
                    state_nx = ST_HELD;
                    cnt_nx   = '0;
                end else if (cnt >= DB_CNT) begin
                    state_nx = ST_IDLE;
                    push     = (REL_EV != 0);
                    push_rel = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        key_in  = (state == ST_HELD) || (state == ST_RELEASE);
        key_val = key_in ? hv : '0;
    end

    key_evfifo #(
        .WIDTH (VAL_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .push     (push),
        .din      ({push_rel, hv}),
        .pop      (ev_ready),
        .dout     (head),
        .empty    (empty),
        .overflow (overflow)
    );

    assign ev_valid = !empty;
    assign ev_rel   = head[VAL_W];
    assign ev_val   = head[VAL_W-1:0];

endmodule

// File: tb/tb_keyenc_scan.sv
// Directed bench for keyenc_scan: one press-only instance and one with release events.
module tb_keyenc_scan;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [15:0] keys0, keys1;
    logic        rdy0, rdy1;
    logic        ki0, ki1, v0, v1, rel0, rel1, ovf0, ovf1;
    logic [3:0]  kv0, kv1, val0, val1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    keyenc_scan #(.NKEYS(16), .VAL_W(4), .DB_CYCLES(4), .DEPTH(4), .REL_EV(0)) dut0 (
        .clock(clock), .reset(reset), .keys(keys0), .clear(clear),
        .key_in(ki0), .key_val(kv0), .ev_valid(v0), .ev_ready(rdy0),
        .ev_val(val0), .ev_rel(rel0), .overflow(ovf0)
    );

    keyenc_scan #(.NKEYS(16), .VAL_W(4), .DB_CYCLES(4), .DEPTH(4), .REL_EV(1)) dut1 (
        .clock(clock), .reset(reset), .keys(keys1), .clear(clear),
        .key_in(ki1), .key_val(kv1), .ev_valid(v1), .ev_ready(rdy1),
        .ev_val(val1), .ev_rel(rel1), .overflow(ovf1)
    );

    typedef struct {
        logic [15:0] keys;
        logic        rdy;
        logic        ki;
        logic [3:0]  kv;
        logic        v;
        logic [3:0]  val;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] k, input logic r, input logic ki, input logic [3:0] kv,
                       input logic v, input logic [3:0] val, input logic ovf);
        vec_t t;
        t.keys = k; t.rdy = r; t.ki = ki; t.kv = kv; t.v = v; t.val = val; t.ovf = ovf;
        tbl.push_back(t);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press_release0(input int k);
        keys0 = 16'(1) << k;
        repeat (8) step();
        keys0 = '0;
        repeat (8) step();
    endtask

    initial begin
        int order [4];
        order = '{13, 14, 15, 2};

        reset = 1'b0; clear = 1'b0;
        keys0 = '0; keys1 = '0; rdy0 = 1'b0; rdy1 = 1'b0;
        repeat (2) step();
        chk("rst key_in0", ki0, 0);   chk("rst ev_valid0", v0, 0);
        chk("rst overflow0", ovf0, 0); chk("rst ev_val0", val0, 0);
        chk("rst key_in1", ki1, 0);   chk("rst ev_valid1", v1, 0);
        reset = 1'b1;
        step();

        // Single clean press of key 5, pop, release
        for (int s = 1; s <= 6; s++)  add(16'h0020, 0, 0, 0, 0, 0, 0);
        for (int s = 7; s <= 8; s++)  add(16'h0020, 0, 1, 5, 1, 5, 0);
        for (int s = 9; s <= 11; s++) add(16'h0020, 1, 1, 5, 0, 0, 0);
        for (int s = 12; s <= 17; s++) add(16'h0000, 1, 1, 5, 0, 0, 0);
        for (int s = 18; s <= 19; s++) add(16'h0000, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            keys0 = tbl[i].keys;
            rdy0  = tbl[i].rdy;
            step();
            chk($sformatf("t1[%0d] key_in", i), ki0, tbl[i].ki);
            chk($sformatf("t1[%0d] key_val", i), kv0, tbl[i].kv);
            chk($sformatf("t1[%0d] ev_valid", i), v0, tbl[i].v);
            chk($sformatf("t1[%0d] ev_val", i), val0, tbl[i].val);
            chk($sformatf("t1[%0d] ev_rel", i), rel0, 0);
            chk($sformatf("t1[%0d] overflow", i), ovf0, tbl[i].ovf);
        end
        rdy0 = 1'b0;

        // Bounce shorter than the debounce window, then a stable press of key 3
        for (int i = 0; i < 8; i++) begin
            keys0 = (i == 0 || i == 2 || i == 3) ? 16'h0008 : 16'h0000;
            step();
            chk("bounce key_in", ki0, 0);
            chk("bounce ev_valid", v0, 0);
        end
        keys0 = 16'h0008;
        repeat (6) step();
        chk("stable early ev_valid", v0, 0);
        step();
        chk("stable ev_valid", v0, 1); chk("stable ev_val", val0, 3);
        chk("stable key_in", ki0, 1);  chk("stable key_val", kv0, 3);
        rdy0 = 1'b1; step(); rdy0 = 1'b0;
        chk("stable single event", v0, 0);
        keys0 = '0;
        repeat (8) step();
        chk("stable released", ki0, 0);

        // Simultaneous keys, no rollover, release event on the REL_EV instance
        keys1 = 16'h8001;
        repeat (6) step();
        chk("multi early ev_valid", v1, 0);
        step();
        chk("multi ev_valid", v1, 1); chk("multi ev_val", val1, 0);
        chk("multi ev_rel", rel1, 0); chk("multi key_in", ki1, 1);
        rdy1 = 1'b1; step(); rdy1 = 1'b0;
        keys1 = 16'h8005;
        repeat (6) step();
        keys1 = 16'h0004;
        repeat (6) step();
        chk("rollover ev_valid", v1, 0); chk("rollover key_val", kv1, 0);
        keys1 = '0;
        repeat (6) step();
        chk("rel early key_in", ki1, 1); chk("rel early ev_valid", v1, 0);
        step();
        chk("rel ev_valid", v1, 1); chk("rel ev_val", val1, 0);
        chk("rel ev_rel", rel1, 1); chk("rel key_in", ki1, 0);
        rdy1 = 1'b1; step(); rdy1 = 1'b0;
        keys1 = 16'h0400;
        repeat (8) step();
        keys1 = '0;
        repeat (8) step();
        chk("k10 press val", val1, 10); chk("k10 press rel", rel1, 0);
        rdy1 = 1'b1; step();
        chk("k10 release val", val1, 10); chk("k10 release rel", rel1, 1);
        step(); rdy1 = 1'b0;
        chk("k10 drained", v1, 0);

        // Overflow with consumer stalled
        press_release0(1); press_release0(2); press_release0(3); press_release0(4);
        chk("fill4 overflow", ovf0, 0); chk("fill4 head", val0, 1);
        press_release0(6);
        chk("fill5 overflow", ovf0, 1);
        press_release0(7);
        chk("fill6 head", val0, 1);
        rdy0 = 1'b1; step(); rdy0 = 1'b0;
        chk("ovf pop head", val0, 2); chk("ovf sticky", ovf0, 1);

        // Clear mid-press: FIFO and flag flushed, FSM continues
        keys0 = 16'h1000;
        repeat (3) step();
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear ev_valid", v0, 0); chk("clear overflow", ovf0, 0);
        repeat (2) step();
        chk("clear still empty", v0, 0);
        step();
        chk("clear fsm kept valid", v0, 1); chk("clear fsm kept val", val0, 12);
        chk("clear fsm key_in", ki0, 1);
        step();
        keys0 = '0;
        repeat (8) step();

        // Push into a full FIFO on a popping edge is accepted
        press_release0(13); press_release0(14); press_release0(15);
        chk("full overflow", ovf0, 0); chk("full head", val0, 12);
        keys0 = 16'h0004;
        repeat (6) step();
        rdy0 = 1'b1; step(); rdy0 = 1'b0;
        chk("push+pop overflow", ovf0, 0); chk("push+pop head", val0, 13);
        step();
        keys0 = '0;
        repeat (8) step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("order[%0d]", i), val0, order[i]);
            rdy0 = 1'b1; step(); rdy0 = 1'b0;
        end
        chk("order drained", v0, 0);

        // Push coinciding with clear is discarded
        keys0 = 16'h0020;
        repeat (6) step();
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear push ev_valid", v0, 0);
        chk("clear push key_in", ki0, 1); chk("clear push key_val", kv0, 5);
        keys0 = '0;
        repeat (8) step();

        // Reset mid-press with a queued event
        press_release0(4);
        keys0 = 16'h0200;
        repeat (4) step();
        reset = 1'b0;
        #1;
        chk("async rst ev_valid", v0, 0); chk("async rst ev_val", val0, 0);
        chk("async rst key_in", ki0, 0);  chk("async rst overflow", ovf0, 0);
        step();
        reset = 1'b1;
        repeat (6) step();
        chk("post rst early ev_valid", v0, 0); chk("post rst early key_in", ki0, 0);
        step();
        chk("post rst ev_valid", v0, 1); chk("post rst ev_val", val0, 9);
        chk("post rst key_val", kv0, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
